// File: rtl/sysid_read_arbiter_if.sv
// Requester-side bus of the system-ID read arbiter: two read ports.
// master = requester side, slave = arbiter side.
`default_nettype none

interface sysid_read_arbiter_if;
    logic        m0_read;
    logic        m0_address;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic        m0_readdatavalid;
    logic        m1_read;
    logic        m1_address;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic        m1_readdatavalid;

    modport master (
        output m0_read, m0_address, m1_read, m1_address,
        input  m0_waitrequest, m0_readdata, m0_readdatavalid,
        input  m1_waitrequest, m1_readdata, m1_readdatavalid
    );

    modport slave (
        input  m0_read, m0_address, m1_read, m1_address,
        output m0_waitrequest, m0_readdata, m0_readdatavalid,
        output m1_waitrequest, m1_readdata, m1_readdatavalid
    );
endinterface

`default_nettype wire

// File: rtl/sysid_read_arbiter.sv
// ============================================================================
// Module  : sysid_read_arbiter
// Purpose : Two-port read arbiter in front of a combinational system-ID slave.
//           Fixed latency: accept N, ISSUE N+1, readdatavalid N+2.
//           Define SYSID_ARB_ROUND_ROBIN_EN for round-robin contests;
//           otherwise requester 0 wins every contest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sysid_read_arbiter (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    sysid_read_arbiter_if.slave       bus,
    output logic                      sid_address,
    input  wire logic [31:0]          sid_readdata
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        sid_address_q, sid_address_d;
    logic        owner_q, owner_d;
    logic [31:0] resp_q, resp_d;
    logic        valid_q, valid_d;

    logic [1:0]  read;
    logic [1:0]  addr;
    logic [1:0]  accept;
    logic        winner;

    assign read = {bus.m1_read,    bus.m0_read};
    assign addr = {bus.m1_address, bus.m0_address};

`ifdef SYSID_ARB_ROUND_ROBIN_EN
    logic        last_grant_q, last_grant_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            sid_address_q <= 1'b0;
            owner_q       <= 1'b0;
            resp_q        <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sid_address_q <= sid_address_d;
            owner_q       <= owner_d;
            resp_q        <= resp_d;
            valid_q       <= valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sid_address_d = sid_address_q;
        owner_d       = owner_q;
        resp_d        = resp_q;
        valid_d       = 1'b0;
        accept        = 2'b00;
        winner        = 1'b0;
`ifdef SYSID_ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|read) begin
                    // A lone requester wins outright; only a contest consults policy.
                    if (read == 2'b11) begin
`ifdef SYSID_ARB_ROUND_ROBIN_EN
                        winner = ~last_grant_q;
`else
                        winner = 1'b0;
`endif
                    end else begin
                        winner = read[1];
                    end
                    accept        = winner ? 2'b10 : 2'b01;
                    sid_address_d = addr[winner];
                    owner_d       = winner;
                    state_d       = S_ISSUE;
`ifdef SYSID_ARB_ROUND_ROBIN_EN
                    last_grant_d  = winner;
`endif
                end
            end
            S_ISSUE: begin
                resp_d  = sid_readdata;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sid_address = sid_address_q;

    assign bus.m0_waitrequest   = read[0] & ~accept[0];
    assign bus.m1_waitrequest   = read[1] & ~accept[1];
    // owner_q only moves at the end of an accept cycle, so it still names the
    // response owner while a back-to-back accept overlaps the valid pulse.
    assign bus.m0_readdatavalid = valid_q & ~owner_q;
    assign bus.m1_readdatavalid = valid_q &  owner_q;
    assign bus.m0_readdata      = resp_q;
    assign bus.m1_readdata      = resp_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_read_arbiter.sv
// Scoreboard bench for sysid_read_arbiter; expectations follow SYSID_ARB_ROUND_ROBIN_EN.
`default_nettype none

module tb_sysid_read_arbiter;

`ifdef SYSID_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [31:0] WORD0 = 32'h0000_0000;
    localparam logic [31:0] WORD1 = 32'h5BA8_D54F;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        sid_address;
    logic [31:0] sid_readdata;

    sysid_read_arbiter_if bus ();

    sysid_read_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .sid_address  (sid_address),
        .sid_readdata (sid_readdata)
    );

    always #5 clock = ~clock;

    assign sid_readdata = sid_address ? WORD1 : WORD0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_rsp(input int port, input logic [31:0] data, input int c);
        sb.push_back('{port: port, data: data, cyc: c});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (bus.m0_readdatavalid || bus.m1_readdatavalid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_valid: got valid {m1,m0}=%b%b, expected none (cycle %0d)",
                         bus.m1_readdatavalid, bus.m0_readdatavalid, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("valid_port", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid},
                      (mon_e.port == 1) ? 32'd2 : 32'd1);
                check("readdata", (mon_e.port == 1) ? bus.m1_readdata : bus.m0_readdata, mon_e.data);
                check("valid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    int n;
    int g;

    initial begin
        bus.m0_read = 1'b0; bus.m0_address = 1'b0;
        bus.m1_read = 1'b0; bus.m1_address = 1'b0;
        reset_n = 1'b0;
        step(); step();
        @(negedge clock);
        check("rst_sidaddr", {31'd0, sid_address}, 32'd0);
        check("rst_valid", {30'd0, bus.m1_readdatavalid, bus.m0_readdatavalid}, 32'd0);
        check("rst_rdata", bus.m0_readdata, 32'd0);
        check("rst_wait", {30'd0, bus.m1_waitrequest, bus.m0_waitrequest}, 32'd0);
        step();
        reset_n = 1'b1;
        step(); step();

        // Single read of the timestamp word
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b1;
        @(negedge clock);
        check("single_wait_accept", {31'd0, bus.m0_waitrequest}, 32'd0);
        expect_rsp(0, WORD1, n + 2);
        step();
        bus.m0_read = 1'b0;
        @(negedge clock);
        check("single_sidaddr", {31'd0, sid_address}, 32'd1);
        check("single_wait_idle", {31'd0, bus.m0_waitrequest}, 32'd0);
        repeat (3) step();

        // Continuous contest from a fresh reset
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b0;
        bus.m1_read = 1'b1; bus.m1_address = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            g = RR ? ((k / 2) % 2) : 0;
            if (k % 2 == 0) begin
                check("contest_wait0", {31'd0, bus.m0_waitrequest}, (g == 0) ? 32'd0 : 32'd1);
                check("contest_wait1", {31'd0, bus.m1_waitrequest}, (g == 1) ? 32'd0 : 32'd1);
                expect_rsp(g, (g == 1) ? WORD1 : WORD0, n + k + 2);
            end else begin
                check("contest_issue_wait", {30'd0, bus.m1_waitrequest, bus.m0_waitrequest}, 32'd3);
            end
            step();
        end
        bus.m0_read = 1'b0; bus.m1_read = 1'b0;
        repeat (3) step();

        // Address isolation: m0 -> word 0, m1 -> word 1
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b0;
        bus.m1_read = 1'b1; bus.m1_address = 1'b1;
        @(negedge clock);
        check("iso_wait", {30'd0, bus.m1_waitrequest, bus.m0_waitrequest}, 32'd2);
        expect_rsp(0, WORD0, n + 2);
        step();
        bus.m0_read = 1'b0;
        @(negedge clock);
        check("iso_issue_wait1", {31'd0, bus.m1_waitrequest}, 32'd1);
        step();
        @(negedge clock);
        check("iso_wait1_accept", {31'd0, bus.m1_waitrequest}, 32'd0);
        expect_rsp(1, WORD1, n + 4);
        step();
        bus.m1_read = 1'b0;
        @(negedge clock);
        check("iso_sidaddr", {31'd0, sid_address}, 32'd1);
        repeat (3) step();

        // Reset pulse during ISSUE drops the in-flight response
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b0;
        @(negedge clock);
        check("rmid_accept", {31'd0, bus.m0_waitrequest}, 32'd0);
        step();
        bus.m0_read = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rmid_sidaddr", {31'd0, sid_address}, 32'd0);
        step(); step();
        reset_n = 1'b1;
        step();
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b1;
        bus.m1_read = 1'b1; bus.m1_address = 1'b0;
        @(negedge clock);
        check("rmid_contest", {30'd0, bus.m1_waitrequest, bus.m0_waitrequest}, 32'd2);
        expect_rsp(0, WORD1, n + 2);
        step();
        bus.m0_read = 1'b0;
        bus.m1_read = 1'b0;
        repeat (3) step();

        // Withdrawn m1 request raised only during ISSUE
        n = cyc;
        bus.m0_read = 1'b1; bus.m0_address = 1'b0;
        @(negedge clock);
        expect_rsp(0, WORD0, n + 2);
        step();
        bus.m0_read = 1'b0;
        bus.m1_read = 1'b1; bus.m1_address = 1'b1;
        @(negedge clock);
        check("wd_issue_wait1", {31'd0, bus.m1_waitrequest}, 32'd1);
        step();
        bus.m1_read = 1'b0;
        @(negedge clock);
        check("wd_wait1_low", {31'd0, bus.m1_waitrequest}, 32'd0);
        step();
        @(negedge clock);
        check("wd_sidaddr", {31'd0, sid_address}, 32'd0);
        repeat (4) step();

        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
